// File: rtl/cpu_pkg.sv
// Shared fetch-side constants and types: word-address/instruction widths, reset PC,
// and the priority-select encoding used by the PC mux.
package cpu_pkg;

    localparam int ADDR_W  = 22;
    localparam int INSTR_W = 32;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam addr_t RESET_PC = '0;

    // Which source wins the PC mux this cycle, lowest to highest priority.
    typedef enum logic [1:0] {
        SEL_SEQ   = 2'd0,
        SEL_STALL = 2'd1,
        SEL_REDIR = 2'd2,
        SEL_HALT  = 2'd3
    } pc_sel_e;

    // Word-address increment; wraps silently at the top of the address space.
    function automatic addr_t pc_inc(input addr_t pc);
        return pc + addr_t'(1);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: memory address/return word plus the decode-side valid/stall handshake
// and control inputs (redirect, halt). master = fetch stage, slave = memory/decode side.
interface instr_fetch_if;
    import cpu_pkg::*;

    logic    stall;
    logic    redirect;
    addr_t   redirect_pc;
    logic    halt;
    addr_t   mem_addr;
    instr_t  mem_instr;
    instr_t  if_instr;
    addr_t   if_pc;
    addr_t   if_pc_plus1;
    logic    if_valid;
    logic [31:0] fetch_cnt;

    modport master (
        input  stall, redirect, redirect_pc, halt, mem_instr,
        output mem_addr, if_instr, if_pc, if_pc_plus1, if_valid, fetch_cnt
    );

    modport slave (
        output stall, redirect, redirect_pc, halt, mem_instr,
        input  mem_addr, if_instr, if_pc, if_pc_plus1, if_valid, fetch_cnt
    );

endinterface

// File: rtl/fetch_pc_sel.sv
// Combinational PC priority mux (halt > redirect > stall > sequential); zero latency.
// Stall re-presents the in-flight address so the memory re-reads the word decode is holding.
module fetch_pc_sel
    import cpu_pkg::*;
(
    input  logic  halt,
    input  logic  halted_q,
    input  logic  redirect,
    input  addr_t redirect_pc,
    input  logic  stall,
    input  addr_t pc_q,
    input  addr_t pc_d1,
    input  logic  vld_q,
    output addr_t mem_addr,
    output addr_t pc_q_nxt,
    output addr_t pc_d1_nxt,
    output logic  vld_nxt,
    output logic  halted_nxt
);

    pc_sel_e sel;

    always_comb begin
        sel = SEL_SEQ;
        if (halt || halted_q) begin
            sel = SEL_HALT;
        end else if (redirect) begin
            sel = SEL_REDIR;
        end else if (stall) begin
            sel = SEL_STALL;
        end
    end

    always_comb begin
        mem_addr   = pc_q;
        pc_q_nxt   = pc_inc(pc_q);
        pc_d1_nxt  = pc_q;
        vld_nxt    = 1'b1;
        halted_nxt = halted_q;
        unique case (sel)
            SEL_HALT: begin
                // Park on the last in-flight address; nothing fetched stays live.
                mem_addr   = pc_d1;
                pc_q_nxt   = pc_q;
                pc_d1_nxt  = pc_d1;
                vld_nxt    = 1'b0;
                halted_nxt = 1'b1;
            end
            SEL_REDIR: begin
                mem_addr  = redirect_pc;
                pc_q_nxt  = pc_inc(redirect_pc);
                pc_d1_nxt = redirect_pc;
                vld_nxt   = 1'b1;
            end
            SEL_STALL: begin
                mem_addr  = pc_d1;
                pc_q_nxt  = pc_q;
                pc_d1_nxt = pc_d1;
                vld_nxt   = vld_q;
            end
            default: begin
                mem_addr  = pc_q;
                pc_q_nxt  = pc_inc(pc_q);
                pc_d1_nxt = pc_q;
                vld_nxt   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives a 1-cycle-latency instruction memory and pairs the word with its PC.
// Redirect costs one bubble; decode stall holds the presented word stable; halt is sticky until rst.
module instr_fetch
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    addr_t       pc_q;
    addr_t       pc_d1;
    logic        vld_q;
    logic        halted_q;
    logic [31:0] cnt_q;

    addr_t sel_addr;
    addr_t pc_q_nxt;
    addr_t pc_d1_nxt;
    logic  vld_nxt;
    logic  halted_nxt;
    logic  xfer;

    fetch_pc_sel u_pc_sel (
        .halt        (bus.halt),
        .halted_q    (halted_q),
        .redirect    (bus.redirect),
        .redirect_pc (bus.redirect_pc),
        .stall       (bus.stall),
        .pc_q        (pc_q),
        .pc_d1       (pc_d1),
        .vld_q       (vld_q),
        .mem_addr    (sel_addr),
        .pc_q_nxt    (pc_q_nxt),
        .pc_d1_nxt   (pc_d1_nxt),
        .vld_nxt     (vld_nxt),
        .halted_nxt  (halted_nxt)
    );

    assign bus.mem_addr    = rst ? RESET_PC : sel_addr;
    assign bus.if_valid    = vld_q & ~bus.halt & ~halted_q & ~bus.redirect & ~rst;
    assign bus.if_instr    = bus.mem_instr;
    assign bus.if_pc       = pc_d1;
    assign bus.if_pc_plus1 = pc_inc(pc_d1);
    assign bus.fetch_cnt   = cnt_q;

    assign xfer = bus.if_valid & ~bus.stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            pc_d1    <= RESET_PC;
            vld_q    <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_q_nxt;
            pc_d1    <= pc_d1_nxt;
            vld_q    <= vld_nxt;
            halted_q <= halted_nxt;
            if (xfer) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 1-cycle memory returning A000_0000 + address.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.mem_instr <= 32'hA000_0000 + 32'(bus.mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs for the new cycle are then applied by the caller.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic expect_word(input string tag, input int pc, input int cnt);
        check({tag, ".valid"}, 32'(bus.if_valid), 32'd1);
        check({tag, ".pc"},    32'(bus.if_pc), 32'(pc));
        check({tag, ".instr"}, bus.if_instr, 32'hA000_0000 + 32'(pc));
        check({tag, ".plus1"}, 32'(bus.if_pc_plus1), 32'((pc + 1) % (1 << 22)));
        check({tag, ".cnt"},   bus.fetch_cnt, 32'(cnt));
    endtask

    task automatic expect_bubble(input string tag, input int addr, input int cnt);
        check({tag, ".valid"}, 32'(bus.if_valid), 32'd0);
        check({tag, ".maddr"}, 32'(bus.mem_addr), 32'(addr));
        check({tag, ".cnt"},   bus.fetch_cnt, 32'(cnt));
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst             = 1'b1;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;

        // Test 1: reset and restart
        next_cycle();
        next_cycle();
        settle();
        expect_bubble("rst", 0, 0);
        rst = 1'b0;
        settle();
        expect_bubble("t1.c1", 0, 0);
        next_cycle(); settle();
        expect_word("t1.c2", 0, 0);
        next_cycle(); settle();
        expect_word("t1.c3", 1, 1);
        for (int i = 2; i <= 4; i++) begin
            next_cycle(); settle();
            expect_word("t1.seq", i, i);
        end

        // Test 2: stall three cycles while if_pc=5
        next_cycle();
        bus.stall = 1'b1;
        settle();
        expect_word("t2.s0", 5, 5);
        for (int i = 0; i < 2; i++) begin
            next_cycle(); settle();
            expect_word("t2.s", 5, 5);
        end
        next_cycle();
        bus.stall = 1'b0;
        settle();
        expect_word("t2.rel", 5, 5);
        next_cycle(); settle();
        expect_word("t2.p6", 6, 6);
        next_cycle(); settle();
        expect_word("t2.p7", 7, 7);

        // Test 3: redirect to 0x100 while if_pc=8
        next_cycle();
        check("t3.pc8", 32'(bus.if_pc), 32'd8);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 22'h100;
        settle();
        expect_bubble("t3.kill", 32'h100, 8);
        next_cycle();
        bus.redirect = 1'b0;
        settle();
        expect_word("t3.tgt", 32'h100, 8);
        next_cycle(); settle();
        expect_word("t3.tgt1", 32'h101, 9);

        // Test 4a: redirect and stall together, redirect wins
        bus.redirect    = 1'b1;
        bus.stall       = 1'b1;
        bus.redirect_pc = 22'h200;
        settle();
        expect_bubble("t4.rs", 32'h200, 9);
        next_cycle();
        bus.redirect = 1'b0;
        bus.stall    = 1'b0;
        settle();
        expect_word("t4.tgt", 32'h200, 9);
        next_cycle(); settle();
        expect_word("t4.tgt1", 32'h201, 10);

        // Test 5: redirect to top of address space, PC wraps
        bus.redirect    = 1'b1;
        bus.redirect_pc = 22'h3FFFFF;
        settle();
        expect_bubble("t5.kill", 32'h3FFFFF, 10);
        next_cycle();
        bus.redirect = 1'b0;
        settle();
        expect_word("t5.top", 32'h3FFFFF, 10);
        next_cycle(); settle();
        expect_word("t5.wrap", 0, 11);

        // Test 4b: halt and redirect together, halt wins and sticks
        bus.halt        = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 22'h50;
        settle();
        expect_bubble("t4.hr", 0, 11);
        next_cycle();
        bus.halt        = 1'b0;
        bus.redirect_pc = 22'h60;
        settle();
        expect_bubble("t4.hredir", 0, 11);
        bus.redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); settle();
            expect_bubble("t4.halted", 0, 11);
            check("t4.hpc", 32'(bus.if_pc), 32'd0);
        end

        // Leave halt via reset and run a few words
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        settle();
        expect_bubble("t6.pre1", 0, 0);
        for (int i = 0; i <= 2; i++) begin
            next_cycle(); settle();
            expect_word("t6.run", i, i);
        end

        // Test 6: reset mid-stream with stall asserted
        rst       = 1'b1;
        bus.stall = 1'b1;
        settle();
        expect_bubble("t6.rst0", 0, 2);
        next_cycle(); settle();
        expect_bubble("t6.rst1", 0, 0);
        next_cycle();
        rst       = 1'b0;
        bus.stall = 1'b0;
        settle();
        expect_bubble("t6.c1", 0, 0);
        next_cycle(); settle();
        expect_word("t6.c2", 0, 0);
        next_cycle(); settle();
        expect_word("t6.c3", 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
